// File: rtl/rr_fifo_arbiter.sv
// Round-robin arbiter that merges N bypass FIFOs into one ready/valid stream
// through a 2-entry first-word-fall-through output buffer, flagging FIFO protocol errors.
module rr_fifo_arbiter #(
  parameter int N     = 3,
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(N)
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic [N-1:0]       i_Req,
  output logic [N-1:0]       o_Grant,
  input  logic [N-1:0]       i_Valid,
  input  logic [N*WIDTH-1:0] i_Data,
  output logic               o_Valid,
  output logic [WIDTH-1:0]   o_Data,
  input  logic               i_Ready,
  output logic               o_Err
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx_q;
  logic             gnt_q;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;

  logic             pop;
  logic [2:0]       occ_sum;
  logic             credit_ok;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;
  logic             grant_en;
  logic [WIDTH-1:0] push_data;
  logic [N-1:0]     expect_valid;
  logic             proto_err;

  assign pop     = o_Valid & i_Ready;
  // Counting the in-flight word guarantees it always lands in a free slot.
  assign occ_sum   = 3'(occ) + 3'(gnt_q) - 3'(pop);
  assign credit_ok = occ_sum < 3'd2;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!win_found && i_Req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign grant_en = Reset_n & win_found & credit_ok;

  always_comb begin
    o_Grant = '0;
    if (grant_en) o_Grant[win_idx] = 1'b1;
  end

  always_comb begin
    push_data = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) push_data = i_Data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    expect_valid = '0;
    if (gnt_q) expect_valid[idx_q] = 1'b1;
  end

  assign proto_err = (|(i_Valid & ~expect_valid)) | (gnt_q & ~i_Valid[idx_q]);

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      ptr    <= '0;
      gnt_q  <= 1'b0;
      idx_q  <= '0;
      occ    <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      o_Err  <= 1'b0;
    end else begin
      gnt_q <= grant_en;
      if (grant_en) begin
        idx_q <= win_idx;
        ptr   <= (win_idx == IDX_W'(N-1)) ? '0 : win_idx + 1'b1;
      end
      occ <= occ_sum[1:0];
      if (proto_err) o_Err <= 1'b1;
      // head_q is always the oldest word; tail_q only holds data when occ is 2.
      case ({gnt_q, pop})
        2'b10: begin
          if (occ == 2'd0) head_q <= push_data;
          else             tail_q <= push_data;
        end
        2'b01: head_q <= tail_q;
        2'b11: begin
          if (occ == 2'd1) head_q <= push_data;
          else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Valid = (occ != 2'd0);
  assign o_Data  = head_q;

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Bench for rr_fifo_arbiter: FIFO response models, a queue-based reference of
// the merged stream checked every cycle, and directed literal expectations.
module tb_rr_fifo_arbiter;
  localparam int N     = 3;
  localparam int WIDTH = 64;

  logic               CLK = 1'b0;
  logic               Reset_n;
  logic [N-1:0]       i_Req;
  logic [N-1:0]       o_Grant;
  logic [N-1:0]       i_Valid;
  logic [N*WIDTH-1:0] i_Data;
  logic               o_Valid;
  logic [WIDTH-1:0]   o_Data;
  logic               i_Ready;
  logic               o_Err;

  rr_fifo_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .i_Req(i_Req), .o_Grant(o_Grant),
    .i_Valid(i_Valid), .i_Data(i_Data), .o_Valid(o_Valid), .o_Data(o_Data),
    .i_Ready(i_Ready), .o_Err(o_Err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int               m_ptr;
  bit               m_inflight;
  int               m_idx;
  logic [WIDTH-1:0] m_q[$];
  bit               m_err;
  int               fifo_seq[N];
  int               exp_seq[N];
  logic [N-1:0]     grant_now;

  logic [N-1:0]     obs_grant;
  logic             obs_valid;
  logic [WIDTH-1:0] obs_data;
  logic             obs_err;

  logic [N-1:0]     g_log[8];
  logic             v_log[8];
  logic [WIDTH-1:0] d_log[8];

  logic [N-1:0] req_tab[7] = '{3'b111, 3'b101, 3'b010, 3'b000, 3'b110, 3'b011, 3'b100};
  logic         rdy_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  // Word tag: FIFO number in the top byte, per-FIFO sequence in the low bits.
  function automatic logic [WIDTH-1:0] word(int k, int s);
    return (WIDTH'(k + 10) << 56) | WIDTH'(s);
  endfunction

  task automatic checkValue(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    m_ptr = 0;
    m_inflight = 0;
    m_idx = 0;
    m_q.delete();
    m_err = 0;
    for (int k = 0; k < N; k++) exp_seq[k] = 0;
  endtask

  // Compares DUT outputs with the reference, then advances the reference across the coming edge.
  task automatic checkOutput();
    logic [N-1:0] eg;
    bit pop;
    int k;
    obs_grant = o_Grant;
    obs_valid = o_Valid;
    obs_data  = o_Data;
    obs_err   = o_Err;
    pop = (m_q.size() > 0) && i_Ready;
    eg = '0;
    if (Reset_n && i_Req != 0 && (m_q.size() + int'(m_inflight) - int'(pop) < 2)) begin
      for (int i = 0; i < N; i++) begin
        if (eg == 0 && i_Req[(m_ptr + i) % N]) eg[(m_ptr + i) % N] = 1'b1;
      end
    end
    checkValue("grant", WIDTH'(o_Grant), WIDTH'(eg));
    checkValue("valid", WIDTH'(o_Valid), WIDTH'(m_q.size() > 0));
    checkValue("err", WIDTH'(o_Err), WIDTH'(m_err));
    if (m_q.size() > 0) checkValue("data", o_Data, m_q[0]);
    if (o_Valid === 1'b1 && i_Ready && Reset_n) begin
      k = int'(o_Data[63:56]) - 10;
      if (k >= 0 && k < N) begin
        checkValue("order", WIDTH'(o_Data[31:0]), WIDTH'(exp_seq[k]));
        exp_seq[k]++;
      end else begin
        checkValue("order_tag", o_Data, word(0, 0));
      end
    end
    grant_now = o_Grant;
    if (!Reset_n) begin
      resetModel();
    end else begin
      if (m_inflight && !i_Valid[m_idx]) m_err = 1;
      for (int j = 0; j < N; j++)
        if (i_Valid[j] && !(m_inflight && m_idx == j)) m_err = 1;
      if (pop) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back(i_Data[m_idx*WIDTH +: WIDTH]);
      m_inflight = 0;
      for (int i = 0; i < N; i++) begin
        if (eg[i]) begin
          m_inflight = 1;
          m_idx = i;
          m_ptr = (i + 1) % N;
        end
      end
    end
  endtask

  task automatic applyStimulus(logic rst_n, logic [N-1:0] req, logic rdy);
    Reset_n = rst_n;
    i_Req   = req;
    i_Ready = rdy;
  endtask

  // One clock: check mid-cycle, then let granted FIFOs present data after the edge.
  task automatic step();
    @(negedge CLK);
    checkOutput();
    @(posedge CLK);
    #1;
    i_Valid = '0;
    for (int k = 0; k < N; k++) i_Data[k*WIDTH +: WIDTH] = 64'hBAD0_0000_0000_0000 | WIDTH'(k);
    if (!Reset_n) begin
      for (int k = 0; k < N; k++) fifo_seq[k] = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (grant_now[k]) begin
          i_Valid[k] = 1'b1;
          i_Data[k*WIDTH +: WIDTH] = word(k, fifo_seq[k]);
          fifo_seq[k]++;
        end
      end
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, 1'b1);
    step();
  endtask

  initial begin
    Reset_n = 1'b0; i_Req = '0; i_Valid = '0; i_Data = '0; i_Ready = 1'b1;
    grant_now = '0;
    resetModel();
    for (int k = 0; k < N; k++) fifo_seq[k] = 0;
    @(posedge CLK);
    #1;

    // Reset held with all requesting
    applyStimulus(1'b0, 3'b111, 1'b1);
    for (int c = 0; c < 2; c++) begin
      step();
      checkValue("rst_grant", WIDTH'(obs_grant), '0);
      checkValue("rst_valid", WIDTH'(obs_valid), '0);
      checkValue("rst_err", WIDTH'(obs_err), '0);
      checkValue("rst_data", obs_data, '0);
    end

    // Full round-robin
    applyStimulus(1'b1, 3'b111, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step();
      g_log[c] = obs_grant; v_log[c] = obs_valid; d_log[c] = obs_data;
    end
    checkValue("rr_g0", WIDTH'(g_log[0]), WIDTH'(3'b001));
    checkValue("rr_g1", WIDTH'(g_log[1]), WIDTH'(3'b010));
    checkValue("rr_g2", WIDTH'(g_log[2]), WIDTH'(3'b100));
    checkValue("rr_g3", WIDTH'(g_log[3]), WIDTH'(3'b001));
    checkValue("rr_v1", WIDTH'(v_log[1]), '0);
    checkValue("rr_v2", WIDTH'(v_log[2]), 64'd1);
    checkValue("rr_v5", WIDTH'(v_log[5]), 64'd1);
    checkValue("rr_d2", d_log[2], word(0, 0));
    checkValue("rr_d3", d_log[3], word(1, 0));
    checkValue("rr_d4", d_log[4], word(2, 0));
    checkValue("rr_d5", d_log[5], word(0, 1));

    // Backpressure for 6 cycles
    applyStimulus(1'b1, 3'b111, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step();
      g_log[c] = obs_grant; v_log[c] = obs_valid; d_log[c] = obs_data;
    end
    checkValue("bp_g0", WIDTH'(g_log[0]), '0);
    checkValue("bp_g5", WIDTH'(g_log[5]), '0);
    checkValue("bp_v5", WIDTH'(v_log[5]), 64'd1);
    checkValue("bp_d0", d_log[0], word(1, 1));
    checkValue("bp_d5", d_log[5], word(1, 1));
    applyStimulus(1'b1, 3'b111, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step();
      g_log[c] = obs_grant; d_log[c] = obs_data;
    end
    checkValue("res_g0", WIDTH'(g_log[0]), WIDTH'(3'b001));
    checkValue("res_d0", d_log[0], word(1, 1));
    checkValue("res_d1", d_log[1], word(2, 1));
    checkValue("res_d2", d_log[2], word(0, 2));

    // Single requester with pointer wrap
    doReset();
    applyStimulus(1'b1, 3'b100, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step();
      g_log[c] = obs_grant; v_log[c] = obs_valid; d_log[c] = obs_data;
    end
    checkValue("one_g0", WIDTH'(g_log[0]), WIDTH'(3'b100));
    checkValue("one_g1", WIDTH'(g_log[1]), WIDTH'(3'b100));
    checkValue("one_g5", WIDTH'(g_log[5]), WIDTH'(3'b100));
    checkValue("one_d2", d_log[2], word(2, 0));
    checkValue("one_d3", d_log[3], word(2, 1));
    checkValue("one_v4", WIDTH'(v_log[4]), 64'd1);

    // Unsolicited valid sets the sticky error
    doReset();
    applyStimulus(1'b1, '0, 1'b1);
    step();
    i_Valid = 3'b010;
    step();
    checkValue("perr_pre", WIDTH'(obs_err), '0);
    step();
    checkValue("perr_set", WIDTH'(obs_err), 64'd1);
    checkValue("perr_occ", WIDTH'(obs_valid), '0);
    step(); step();
    checkValue("perr_hold", WIDTH'(obs_err), 64'd1);
    doReset();
    step();
    checkValue("perr_clr", WIDTH'(obs_err), '0);

    // Granted FIFO fails to present valid
    applyStimulus(1'b1, 3'b001, 1'b1);
    step();
    checkValue("miss_g", WIDTH'(obs_grant), WIDTH'(3'b001));
    applyStimulus(1'b1, '0, 1'b1);
    i_Valid = '0;
    step();
    checkValue("miss_pre", WIDTH'(obs_err), '0);
    step();
    checkValue("miss_set", WIDTH'(obs_err), 64'd1);

    // Sparse one-cycle request
    doReset();
    applyStimulus(1'b1, 3'b010, 1'b1);
    step();
    checkValue("sp_g", WIDTH'(obs_grant), WIDTH'(3'b010));
    applyStimulus(1'b1, '0, 1'b1);
    for (int c = 1; c < 5; c++) begin
      step();
      v_log[c] = obs_valid; d_log[c] = obs_data;
    end
    checkValue("sp_v1", WIDTH'(v_log[1]), '0);
    checkValue("sp_v2", WIDTH'(v_log[2]), 64'd1);
    checkValue("sp_d2", d_log[2], word(1, 0));
    checkValue("sp_v3", WIDTH'(v_log[3]), '0);
    checkValue("sp_v4", WIDTH'(v_log[4]), '0);
    applyStimulus(1'b1, 3'b111, 1'b1);
    step();
    checkValue("sp_ptr", WIDTH'(obs_grant), WIDTH'(3'b100));

    // Mixed request and ready patterns
    doReset();
    for (int c = 0; c < 48; c++) begin
      applyStimulus(1'b1, req_tab[c % 7], rdy_tab[c % 5]);
      step();
    end
    applyStimulus(1'b1, '0, 1'b1);
    for (int c = 0; c < 4; c++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
